zap_store_drain: RTL

- Sits directly downstream of the synchronous store FIFO and drains it onto a Wishbone B3 master port.
- Each FIFO entry is one buffered word write.
- Runs of consecutive word addresses are merged into incrementing bursts; all other entries become single classic cycles.
- Bus errors are recorded in sticky status, and draining then continues.

---
 rtl/zap_store_drain.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/zap_store_drain.sv
// ============================================================================
// zap_store_drain
//   Drains the synchronous store FIFO onto a Wishbone B3 master port. Every
//   FIFO entry is one buffered word write. Runs of consecutive word addresses
//   are merged into incrementing bursts, and a burst never crosses a
//   MAX_BURST*4-byte aligned boundary. Every other entry becomes a single
//   classic cycle. A bus error is recorded in sticky status and draining then
//   continues.
//
// Optional feature (macro ZAP_DRAIN_TIMEOUT_EN):
//   Enables an ack watchdog. After TIMEOUT_CYCLES cycles in WAIT with no
//   ack and no err, the beat is treated exactly as if i_wb_err had arrived.
//   When the macro is not defined, WAIT waits indefinitely and
//   TIMEOUT_CYCLES has no effect.
//
// Ports:
//   i_clk, i_reset          clock and asynchronous active-high reset
//   i_fifo_data[65:0]       FIFO head entry {sel[3:0], word adr[29:0], dat[31:0]}
//   i_fifo_empty            FIFO empty flag
//   o_fifo_ack              combinational pop strobe to the FIFO
//   o_wb_*                  registered Wishbone B3 master outputs
//   i_wb_ack, i_wb_err      slave acknowledge and slave error
//   o_idle                  high in IDLE when no cycle is open
//   o_err, o_err_adr        sticky error flag and byte address of the
//                           first errored beat
//   i_err_clr               synchronous clear pulse for o_err
// ============================================================================
module zap_store_drain #(
   parameter int unsigned MAX_BURST      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [65:0] i_fifo_data,
   input  logic        i_fifo_empty,
   output logic        o_fifo_ack,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic [2:0]  o_wb_cti,
   output logic [1:0]  o_wb_bte,
   input  logic        i_wb_ack,
   input  logic        i_wb_err,
   output logic        o_idle,
   output logic        o_err,
   output logic [31:0] o_err_adr,
   input  logic        i_err_clr
);

   localparam int unsigned BW = $clog2(MAX_BURST);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

   state_t      state_q;
   logic [29:0] adr_q;
   logic [31:0] dat_q;
   logic [3:0]  sel_q;
   logic        cyc_q, stb_q;
   logic [31:0] wb_adr_q, wb_dat_q;
   logic [3:0]  wb_sel_q;
   logic [2:0]  cti_q;
   logic        err_q;
   logic [31:0] err_adr_q;

   logic [3:0]  head_sel;
   logic [29:0] head_wadr;
   logic [31:0] head_dat;
   logic        cont_d, timeout, fifo_ack_d;

   assign head_sel  = i_fifo_data[65:62];
   assign head_wadr = i_fifo_data[61:32];
   assign head_dat  = i_fifo_data[31:0];

   // The burst may continue only onto the next word, and only if the current
   // beat is not the last word of its aligned block. The block rule also
   // stops a wrap from 0x3FFFFFFF to 0.
   assign cont_d = !i_fifo_empty && (head_sel != 4'h0) &&
                   (head_wadr == adr_q + 30'd1) && !(&adr_q[BW-1:0]);

`ifdef ZAP_DRAIN_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmr_q;

   // Held at zero outside WAIT, so every entry into WAIT restarts the count.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                tmr_q <= '0;
      else if (state_q != S_WAIT) tmr_q <= '0;
      else                        tmr_q <= tmr_q + 1'b1;
   end

   assign timeout = (state_q == S_WAIT) && !i_wb_ack && !i_wb_err &&
                    (tmr_q == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // Pop strobe. In IDLE, every head entry is popped, including sel==0
   // entries, which are discarded. Inside a burst, the next head entry is
   // popped on the ack of a non-final beat; an error suppresses that pop.
   always_comb begin
      fifo_ack_d = 1'b0;
      case (state_q)
         S_IDLE:  fifo_ack_d = !i_fifo_empty;
         S_WAIT:  fifo_ack_d = i_wb_ack && !i_wb_err && (cti_q == 3'b010);
         default: fifo_ack_d = 1'b0;
      endcase
      if (i_reset) fifo_ack_d = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         wb_adr_q  <= '0;
         wb_dat_q  <= '0;
         wb_sel_q  <= '0;
         cti_q     <= '0;
         err_q     <= 1'b0;
         err_adr_q <= '0;
      end else begin
         // A clear is overridden below by an error that is set in the same cycle.
         if (i_err_clr) err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!i_fifo_empty && (head_sel != 4'h0)) begin
                  adr_q   <= head_wadr;
                  dat_q   <= head_dat;
                  sel_q   <= head_sel;
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               cyc_q    <= 1'b1;
               stb_q    <= 1'b1;
               wb_adr_q <= {adr_q, 2'b00};
               wb_dat_q <= dat_q;
               wb_sel_q <= sel_q;
               cti_q    <= cont_d ? 3'b010 : 3'b111;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (i_wb_err || timeout) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  state_q <= S_IDLE;
                  if (!err_q) begin
                     err_q     <= 1'b1;
                     err_adr_q <= wb_adr_q;
                  end
               end else if (i_wb_ack) begin
                  stb_q <= 1'b0;
                  if (cti_q == 3'b010) begin
                     // Master wait state: cyc stays high while the next beat is fetched.
                     adr_q   <= head_wadr;
                     dat_q   <= head_dat;
                     sel_q   <= head_sel;
                     state_q <= S_FETCH;
                  end else begin
                     cyc_q   <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_fifo_ack = fifo_ack_d;
   assign o_wb_cyc   = cyc_q;
   assign o_wb_stb   = stb_q;
   assign o_wb_we    = cyc_q;
   assign o_wb_adr   = wb_adr_q;
   assign o_wb_dat   = wb_dat_q;
   assign o_wb_sel   = wb_sel_q;
   assign o_wb_cti   = cti_q;
   assign o_wb_bte   = 2'b00;
   assign o_idle     = (state_q == S_IDLE) && !cyc_q;
   assign o_err      = err_q;
   assign o_err_adr  = err_adr_q;

endmodule
